// File: rtl/shift_rot_pkg.sv
// shift_rot_pkg: shared mode and FSM state types for the shift/rotate engine.
package shift_rot_pkg;
   typedef enum logic [1:0] {ROL = 2'b00, ROR = 2'b01, SHL = 2'b10, SHR = 2'b11} mode_t;
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/shift_rot_step.sv
// shift_rot_step: combinational single 1-bit shift/rotate step.
// SHIFT_ROT_ARITH_EN makes SHR arithmetic (sign fill) instead of filling from ser_in.
module shift_rot_step
   import shift_rot_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] data,
   input  mode_t            mode,
   input  logic             ser_in,
   output logic [WIDTH-1:0] nxt,
   output logic             carry
);
   logic fill;
`ifdef SHIFT_ROT_ARITH_EN
   assign fill = data[WIDTH-1];
`else
   assign fill = ser_in;
`endif
   always_comb begin
      nxt   = (mode == ROL) ? {data[WIDTH-2:0], data[WIDTH-1]} :
              (mode == ROR) ? {data[0], data[WIDTH-1:1]} :
              (mode == SHL) ? {data[WIDTH-2:0], ser_in} :
                              {fill, data[WIDTH-1:1]};
      carry = (mode == ROL || mode == SHL) ? data[WIDTH-1] : data[0];
   end
endmodule

// File: rtl/shift_rot_engine.sv
// shift_rot_engine: loadable register executing N 1-bit shift/rotate steps per command.
// Build option SHIFT_ROT_ARITH_EN selects arithmetic SHR (see shift_rot_step).
module shift_rot_engine
   import shift_rot_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] count,
   input  logic             ser_in,
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic             busy,
   output logic             done
);
   state_t           state;
   mode_t            mode_q;
   logic [CNT_W-1:0] rem;
   logic [WIDTH-1:0] step_out;
   logic             step_carry;
   shift_rot_step #(.WIDTH(WIDTH)) u_step (
      .data   (out),
      .mode   (mode_q),
      .ser_in (ser_in),
      .nxt    (step_out),
      .carry  (step_carry)
   );
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state  <= IDLE;
         mode_q <= ROL;
         rem    <= '0;
         out    <= '0;
         carry  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         // load wins in both states; in RUN it aborts the command silently
         if (load_en) begin
            out   <= load_val;
            carry <= 1'b0;
            state <= IDLE;
            busy  <= 1'b0;
         end else if (state == IDLE) begin
            if (start) begin
               mode_q <= mode_t'(mode);
               rem    <= count;
               if (count == '0) begin
                  done <= 1'b1;
               end else begin
                  state <= RUN;
                  busy  <= 1'b1;
               end
            end
         end else begin
            out   <= step_out;
            carry <= step_carry;
            rem   <= rem - 1'b1;
            if (rem == CNT_W'(1)) begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
         end
      end
   end
endmodule

// File: doc/shift_rot_engine.md
# shift_rot_engine

Parametrised multi-step shift/rotate register for general datapath use. It loads a word in parallel, then executes a commanded number of 1-bit shift or rotate steps, one per clock. Four modes are supported, with a serial fill input, a carry-out of the last bit shifted out, and a busy/done handshake. It generalises the fixed 8-bit free-running rotate-left register used elsewhere in the design.

## Interface
- WIDTH, 8: data width, ≥2
- CNT_W, 4: step-count width; max steps per command 2^CNT_W−1
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset; reset is rstn, synchronous, active-low, on clock clk
- load_en  in  1  parallel load strobe
- load_val  in  WIDTH  parallel load data
- start  in  1  command strobe, sampled only in IDLE
- mode  in  2  00 ROL, 01 ROR, 10 SHL (logical left), 11 SHR (right)
- count  in  CNT_W  number of 1-bit steps
- ser_in  in  1  fill bit for SHL/SHR
- out  out  WIDTH  register contents
- carry  out  1  last bit shifted or rotated out
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, RUN.
- Reset: out=0, carry=0, busy=0, done=0, state=IDLE. Applies mid-command; the command is discarded.
- IDLE, load_en=1: out←load_val, carry←0. load_en has priority over start.
- IDLE, start=1, load_en=0:
  - Latch mode and count.
  - count=0: done=1 for one cycle, out unchanged, stay IDLE.
  - Otherwise: go to RUN, busy=1.
- RUN: one step per cycle, then decrement the remaining count.
  - ROL: out←{out[W−2:0],out[W−1]}, carry←out[W−1].
  - ROR: out←{out[0],out[W−1:1]}, carry←out[0].
  - SHL: out←{out[W−2:0],ser_in}, carry←out[W−1].
  - SHR: out←{fill,out[W−1:1]}, carry←out[0]. fill is defined under Configuration.
- After the last step: state←IDLE, busy←0, done←1 for that one cycle.
- RUN, load_en=1: abort. out←load_val, carry←0, state←IDLE, busy←0, no done pulse.
- start while busy: ignored.
- mode, count and load_val are sampled only when stated above. mode/count changes during RUN have no effect.
- ser_in is sampled every RUN step.

## Timing
- start sampled at edge E0 with count=N>0:
  - busy=1 from E0.
  - Steps occur at edges E1..EN.
  - At EN: busy=0, done=1 for exactly one cycle.
  - The next start is accepted at EN+1 at the earliest; a start in the done cycle is accepted.
- count=0: done=1 registered at E0; busy never asserts.
- Load: out valid the cycle after the load edge (1-cycle latency).
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- SHIFT_ROT_ARITH_EN defined: SHR is arithmetic. fill=out[W−1] (sign preserved); ser_in is ignored in SHR.
- Undefined: SHR is logical. fill=ser_in.
- Other modes are unaffected by the macro.

## Structure
- Package shift_rot_pkg:
  - mode enum typedef (ROL/ROR/SHL/SHR).
  - FSM state enum (IDLE/RUN).
- Sub-module shift_rot_step: purely combinational single-step unit.
  - Inputs: data, mode, ser_in.
  - Outputs: next data, carry.
  - Parametrised by WIDTH.
  - The SHIFT_ROT_ARITH_EN fill select lives here.
- Top level holds the FSM, step counter, out/carry registers and the handshake.

## Test plan
- WIDTH=8. Load 0x81, start ROL count=1 → out=0x03, carry=1. Busy lasts one cycle, then a done pulse.
- Load 0x01, ROR count=3 → steps 0x80, 0x40, 0x20; final carry=0. Done at E3, busy high for exactly 3 cycles.
- Load 0x0F, SHL count=4, ser_in=1 → 0xFF, carry=0. Then SHL count=1, ser_in=0 → 0xFE, carry=1.
- Load 0x80, SHR count=3, ser_in=0:
  - With SHIFT_ROT_ARITH_EN → 0xF0.
  - Without → 0x10.
  - carry=0 in both builds.
- Abort: load 0x01, ROL count=8, assert load_en=0x55 at E3 → out=0x55, carry=0, busy=0, no done. A start at the next cycle is accepted.
- count=0 start → done next cycle, busy=0, out unchanged.
- rstn low at E2 of a count=5 run → out=0, carry=0, busy=0, done=0, IDLE.
